shift_add_mul: RTL and testbench
================================

// Module: shift_add_mul
// PURPOSE
//   Iterative unsigned shift-and-add multiplier for the 8-bit ALU datapath.
//   Drives one RCA adder instance, one partial-product add per cycle, and
//   consumes its SIZE+1-bit sum/carry. Produces a 2*SIZE-bit product after
//   SIZE iterations. Sits beside the adder as the ALU's MUL functional unit.
// PARAMETERS
//   SIZE  8  operand width in bits; product width is 2*SIZE; SIZE >= 2
// PORTS
//   clk      in   1         clock; all state updates on the rising edge
//   rst_n    in   1         asynchronous, active-low reset
//   start    in   1         request; sampled only when busy == 0
//   a        in   SIZE      multiplicand; captured on the accepting edge
//   b        in   SIZE      multiplier; captured on the accepting edge
//   busy     out  1         1 while iterating (state RUN)
//   done     out  1         single-cycle pulse: product valid and new
//   product  out  2*SIZE    result register; holds until the next accepted start
// BEHAVIOUR
//   - Reset (rst_n = 0, asynchronous): state = IDLE; busy, done, product,
//     cnt and all internal registers = 0. Applies immediately, including mid-RUN;
//     the in-flight operation is discarded and no done pulse is produced for it.
//   - FSM states IDLE, RUN, DONE:
//     IDLE -start-> RUN. RUN -cnt==SIZE-1-> DONE. DONE -start-> RUN, else IDLE.
//   - Accept edge (IDLE or DONE with start = 1): mcand <= a; acc <= {SIZE'b0, b};
//     cnt <= 0; state <= RUN. start is ignored during RUN; no queueing.
//   - RUN iteration, one per cycle:
//     RCA inputs are acc[2S-1:S] and (acc[0] ? mcand : 0).
//     sum[S:0] = RCA result.
//     acc <= {sum[S:0], acc[S-1:1]} (the carry shifts into the MSB). cnt <= cnt + 1.
//   - Latency: start accepted at edge E0. done = 1 for exactly one cycle after edge
//     E0+SIZE. product <= acc at that edge.
//     Back-to-back: start during DONE is accepted. The next done follows SIZE
//     cycles later.
//   - busy = (state == RUN). done = (state == DONE). Both are registered-state
//     decodes and glitch-free.
//   - Arithmetic: unsigned, exact. A product of 2*SIZE bits cannot overflow.
//     0 * x = 0 still takes the full SIZE cycles (fixed latency).
//   - cnt width = $clog2(SIZE). It never wraps inside RUN, because the exit is
//     at SIZE-1.
// CONFIGURATION
//   MUL_OVF_EN defined: adds output port ovf (1 bit). The reset value of ovf is 0.
//     ovf is registered together with product: ovf <= |acc_final[2S-1:S], which
//     flags that the result does not fit in SIZE bits. It holds with product.
//   MUL_OVF_EN undefined: there is no ovf port and no associated logic.
//   All other behaviour is identical in both cases.
// STRUCTURE
//   - Package mul_pkg contains:
//     - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
//     - function cnt_w(size) returning $clog2(size).
//   - One sub-module: the existing RCA #(SIZE). It is the combinational adder
//     in the iteration path. No other adder is inferred.
//   - One always_ff for state/cnt/acc/mcand/product. A combinational next-state block.
// TESTING
//   All tests use SIZE = 8 unless stated otherwise.
//   1. Reset then a = 3, b = 5, start for 1 cycle:
//      - busy = 1 for 8 cycles;
//      - done pulses after edge E0+8;
//      - product = 16'h000F.
//   2. a = 8'hFF, b = 8'hFF -> product = 16'hFE01. With MUL_OVF_EN: ovf = 1.
//      a = 8'h0F, b = 8'h0F -> product = 16'h00E1, ovf = 0.
//   3. a = 0, b = 8'hA5 -> product = 0 after the full 8 cycles.
//      Verify done timing is unchanged.
//   4. start a = 2, b = 3. At cycle 3 of RUN, drive start with a = 9, b = 9.
//      The second request is ignored: product = 6, and only one done pulse occurs.
//   5. Reset mid-op: start a = 7, b = 7 and drop rst_n at cycle 4:
//      - busy, done and product go to 0 immediately;
//      - no done pulse appears after release.
//   6. Back-to-back: hold start high through DONE with new a = 12, b = 11.
//      - first done carries the first result;
//      - second product = 132 arrives 8 cycles later.
//      At SIZE = 2, run an exhaustive 4x4 sweep against a*b.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier (shift_add_mul).
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  function automatic int cnt_w(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/shift_add_mul_rca.sv
// Ripple-carry adder: SIZE-bit operands, SIZE+1-bit result with carry out on top.
module rca #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [SIZE:0]   sum_o
);

  logic [SIZE:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o[SIZE] = carry[SIZE];

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier, one partial product per cycle.
// Optional MUL_OVF_EN adds an ovf output flagging products wider than SIZE bits.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product,
`ifdef MUL_OVF_EN
  output logic              ovf,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CW = cnt_w(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  // Handshake: start is a level request; it is taken on any rising edge where
  // the unit is not in RUN (IDLE or DONE). There is no back-pressure and no queue.
  mul_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0] acc_q, acc_d, acc_step;
  logic [2*SIZE-1:0] product_q, product_d;
  logic [SIZE-1:0]   mcand_q, mcand_d, addend;
  logic [SIZE:0]     sum;
  logic              accept;
`ifdef MUL_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  assign accept = start && (state_q != RUN);
  assign addend = acc_q[0] ? mcand_q : '0;

  rca #(.SIZE(SIZE)) u_rca (
    .a_i   (acc_q[2*SIZE-1:SIZE]),
    .b_i   (addend),
    .sum_o (sum)
  );

  // The adder carry becomes the new MSB as the accumulator shifts right.
  assign acc_step = {sum, acc_q[SIZE-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
`ifdef MUL_OVF_EN
    ovf_d     = ovf_q;
`endif
    if (accept) begin
      mcand_d = a;
      acc_d   = {{SIZE{1'b0}}, b};
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        product_d = acc_step;
`ifdef MUL_OVF_EN
        ovf_d     = |acc_step[2*SIZE-1:SIZE];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
`ifdef MUL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
`ifdef MUL_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign product   = product_q;
  assign dbg_state = state_q;
`ifdef MUL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed plus random checks of shift_add_mul at SIZE=8, and an exhaustive sweep at SIZE=2.
module tb_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [15:0] product;
  logic [1:0]  dbg_state;

  logic        start2 = 1'b0;
  logic [1:0]  a2 = '0;
  logic [1:0]  b2 = '0;
  logic        busy2, done2;
  logic [3:0]  product2;
  logic [1:0]  dbg_state2;
`ifdef MUL_OVF_EN
  logic        ovf, ovf2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_add_mul #(.SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
`ifdef MUL_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  shift_add_mul #(.SIZE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(product2),
`ifdef MUL_OVF_EN
    .ovf(ovf2),
`endif
    .dbg_state(dbg_state2)
  );

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return {8'h00, x} * {8'h00, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the accepting edge; leaves in the cycle where done is high.
  task automatic wait_result(input string tag, input logic [15:0] exp_p);
    for (int k = 0; k < 8; k++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done_early"}, 32'(done), 32'd0);
      tick();
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_off"}, 32'(busy), 32'd0);
    check({tag, " product"}, 32'(product), 32'(exp_p));
`ifdef MUL_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(exp_p > 16'd255));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int done_at;
    logic [7:0] rx, ry;

    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product", 32'(product), 32'd0);
    check("rst busy2", 32'(busy2), 32'd0);
    check("rst product2", 32'(product2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    launch(8'd3, 8'd5);
    wait_result("t1", 16'h000F);
    tick();
    check("t1 done_single", 32'(done), 32'd0);

    launch(8'hFF, 8'hFF);
    wait_result("t2a", 16'hFE01);
    tick();
    launch(8'h0F, 8'h0F);
    wait_result("t2b", 16'h00E1);
    tick();

    launch(8'h00, 8'hA5);
    wait_result("t3", 16'h0000);
    tick();

    launch(8'd2, 8'd3);
    pulses = 0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3);
      a = (c == 3) ? 8'd9 : 8'd2;
      b = (c == 3) ? 8'd9 : 8'd3;
      tick();
      if (done) begin
        pulses++;
        done_at = c;
        check("t4 product", 32'(product), 32'd6);
      end
    end
    start = 1'b0;
    check("t4 pulses", 32'(pulses), 32'd1);
    check("t4 done_at", 32'(done_at), 32'd8);
    check("t4 idle", 32'(busy), 32'd0);

    launch(8'd7, 8'd7);
    tick();
    tick();
    tick();
    check("t5 busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 busy_rst", 32'(busy), 32'd0);
    check("t5 done_rst", 32'(done), 32'd0);
    check("t5 product_rst", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) pulses++;
    end
    check("t5 no_done", 32'(pulses), 32'd0);
    check("t5 product_hold", 32'(product), 32'd0);

    start = 1'b1;
    a = 8'd13;
    b = 8'd17;
    tick();
    a = 8'd12;
    b = 8'd11;
    wait_result("t6a", model(8'd13, 8'd17));
    tick();
    start = 1'b0;
    wait_result("t6b", 16'd132);
    tick();

    for (int n = 0; n < 24; n++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      launch(rx, ry);
      wait_result("rnd", model(rx, ry));
      tick();
    end

    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        start2 = 1'b1;
        a2 = 2'(x);
        b2 = 2'(y);
        tick();
        start2 = 1'b0;
        check("s2 busy_c1", 32'(busy2), 32'd1);
        tick();
        check("s2 busy_c2", 32'(busy2), 32'd1);
        tick();
        check("s2 done", 32'(done2), 32'd1);
        check("s2 product", 32'(product2), 32'(x * y));
`ifdef MUL_OVF_EN
        check("s2 ovf", 32'(ovf2), 32'((x * y) > 3));
`endif
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
